// File: rtl/csr_file_trap.sv
// ---------------------------------------------------------------------------
// csr_file_trap
//
// Machine-mode CSR unit. Decodes the implemented CSRs, performs atomic
// CSRRW/CSRRS/CSRRC read-modify-write, flags illegal accesses, sequences
// trap entry and mret with a registered PC redirect, and keeps the 64-bit
// mcycle/minstret counters.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   csr_en/op/addr/src  CSR instruction from EX (op: 01 RW, 10 RS, 11 RC)
//   csr_nowr            RS/RC source is x0/zero uimm, so no write happens
//   csr_rdata           pre-write CSR value (0 on an illegal access), comb.
//   csr_illegal         illegal access flag, combinational
//   trap_req/cause/pc/val  trap entry request from the commit point
//   mret_req            mret request from the commit point
//   retire              one instruction retired this cycle
//   redirect_valid/pc   registered one-cycle PC redirect
//   mstatus_mie         global interrupt enable
//   csr_mtvec/csr_mepc  live copies of mtvec and mepc
// ---------------------------------------------------------------------------
module csr_file_trap #(
    parameter int          XLEN         = 32,
    parameter logic [31:0] MSTATUS_RST  = 32'h0000_1800,
    parameter logic [31:0] MTVEC_RST    = 32'h0000_0170,
    parameter logic [31:0] MEPC_RST     = 32'h0001_0000,
    parameter bit          HAS_COUNTERS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_en,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_src,
    input  logic            csr_nowr,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_val,
    input  logic            mret_req,
    input  logic            retire,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            mstatus_mie,
    output logic [XLEN-1:0] csr_mtvec,
    output logic [XLEN-1:0] csr_mepc
);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    // Architectural state. Only MIE and MPIE of mstatus are real flops;
    // MPP is hardwired to machine mode.
    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [63:0]     mcycle_q, mcycle_d;
    logic [63:0]     minstret_q, minstret_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    logic            addr_impl;
    logic            addr_counter;
    logic [XLEN-1:0] read_val;
    logic [XLEN-1:0] write_val;
    logic            wants_write;
    logic            do_write;

    // Address decode and read mux. Counter addresses stay implemented when
    // the counters are absent so that they read as zero; writing them is
    // then rejected by the legality check below.
    always_comb begin
        addr_impl    = 1'b0;
        addr_counter = 1'b0;
        read_val     = '0;
        unique case (csr_addr)
            12'h300: begin
                addr_impl    = 1'b1;
                read_val[12:11] = 2'b11;
                read_val[7]  = mpie_q;
                read_val[3]  = mie_q;
            end
            12'h305: begin addr_impl = 1'b1; read_val = mtvec_q;    end
            12'h340: begin addr_impl = 1'b1; read_val = mscratch_q; end
            12'h341: begin addr_impl = 1'b1; read_val = mepc_q;     end
            12'h342: begin addr_impl = 1'b1; read_val = mcause_q;   end
            12'h343: begin addr_impl = 1'b1; read_val = mtval_q;    end
            12'hB00, 12'hC00: begin
                addr_impl    = 1'b1;
                addr_counter = 1'b1;
                read_val     = HAS_COUNTERS ? mcycle_q[31:0] : '0;
            end
            12'hB80, 12'hC80: begin
                addr_impl    = 1'b1;
                addr_counter = 1'b1;
                read_val     = HAS_COUNTERS ? mcycle_q[63:32] : '0;
            end
            12'hB02, 12'hC02: begin
                addr_impl    = 1'b1;
                addr_counter = 1'b1;
                read_val     = HAS_COUNTERS ? minstret_q[31:0] : '0;
            end
            12'hB82, 12'hC82: begin
                addr_impl    = 1'b1;
                addr_counter = 1'b1;
                read_val     = HAS_COUNTERS ? minstret_q[63:32] : '0;
            end
            default: begin
                addr_impl = 1'b0;
            end
        endcase
    end

    // Legality and the read-modify-write value. RS/RC with a zero source
    // are pure reads, which is what makes reads of read-only CSRs legal.
    always_comb begin
        wants_write = csr_en && (csr_op != OP_NONE) &&
                      !(((csr_op == OP_RS) || (csr_op == OP_RC)) && csr_nowr);
        csr_illegal = csr_en && (!addr_impl || (csr_op == OP_NONE) ||
                      (wants_write && ((csr_addr[11:10] == 2'b11) ||
                                       (addr_counter && !HAS_COUNTERS))));
        csr_rdata   = csr_illegal ? '0 : read_val;
        unique case (csr_op)
            OP_RW:   write_val = csr_src;
            OP_RS:   write_val = read_val | csr_src;
            OP_RC:   write_val = read_val & ~csr_src;
            default: write_val = read_val;
        endcase
        // Traps and mret take precedence and squash a same-cycle CSR write.
        do_write = wants_write && !csr_illegal && !trap_req && !mret_req;
    end

    // Next-state logic: trap entry beats mret beats a CSR write. The
    // counters run independently, except that a write to either half of a
    // counter replaces that half and skips the increment for that cycle.
    always_comb begin
        mie_d            = mie_q;
        mpie_d           = mpie_q;
        mtvec_d          = mtvec_q;
        mscratch_d       = mscratch_q;
        mepc_d           = mepc_q;
        mcause_d         = mcause_q;
        mtval_d          = mtval_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        mcycle_d         = mcycle_q + 64'd1;
        minstret_d       = minstret_q + {63'd0, retire};

        if (trap_req) begin
            mepc_d           = {trap_pc[XLEN-1:2], 2'b00};
            mcause_d         = trap_cause;
            mtval_d          = trap_val;
            mpie_d           = mie_q;
            mie_d            = 1'b0;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = mtvec_q;
        end else if (mret_req) begin
            mie_d            = mpie_q;
            mpie_d           = 1'b1;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = mepc_q;
        end else if (do_write) begin
            unique case (csr_addr)
                12'h300: begin
                    mie_d  = write_val[3];
                    mpie_d = write_val[7];
                end
                12'h305: mtvec_d    = {write_val[XLEN-1:2], 2'b00};
                12'h340: mscratch_d = write_val;
                12'h341: mepc_d     = {write_val[XLEN-1:2], 2'b00};
                12'h342: mcause_d   = write_val;
                12'h343: mtval_d    = write_val;
                12'hB00: mcycle_d   = {mcycle_q[63:32], write_val};
                12'hB80: mcycle_d   = {write_val, mcycle_q[31:0]};
                12'hB02: minstret_d = {minstret_q[63:32], write_val};
                12'hB82: minstret_d = {write_val, minstret_q[31:0]};
                default: begin
                    mscratch_d = mscratch_q;
                end
            endcase
        end

        if (!HAS_COUNTERS) begin
            mcycle_d   = '0;
            minstret_d = '0;
        end
    end

    // State register; reset also kills a redirect that is in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mie_q            <= MSTATUS_RST[3];
            mpie_q           <= MSTATUS_RST[7];
            mtvec_q          <= MTVEC_RST;
            mscratch_q       <= '0;
            mepc_q           <= MEPC_RST;
            mcause_q         <= '0;
            mtval_q          <= '0;
            mcycle_q         <= '0;
            minstret_q       <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            mie_q            <= mie_d;
            mpie_q           <= mpie_d;
            mtvec_q          <= mtvec_d;
            mscratch_q       <= mscratch_d;
            mepc_q           <= mepc_d;
            mcause_q         <= mcause_d;
            mtval_q          <= mtval_d;
            mcycle_q         <= mcycle_d;
            minstret_q       <= minstret_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign mstatus_mie    = mie_q;
    assign csr_mtvec      = mtvec_q;
    assign csr_mepc       = mepc_q;

endmodule
